lu_row_mem_ctrl: RTL and testbench
==================================

# lu_row_mem_ctrl

Row-buffer controller and arbiter for the LU decomposition engine. It holds the SIZE-row complex matrix. The host side loads and unloads rows while the engine is idle. During a run, the engine side gets exclusive ownership with 1-cycle row reads and write-backs. The block also sequences the engine start, run-completion detection, flush and a run-cycle counter.

## Interface
Parameters:
- SIZE, 4, matrix dimension (rows, and complex elements per row); power of two ≥2
- WIDTH, 64, bits per real or imaginary part; a row is ROW_W = SIZE*2*WIDTH bits, element j = {imag, real} at bits [j*2*WIDTH +: 2*WIDTH]

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  host request to begin a run
- flush_i  in  1  abort and return to IDLE
- host_wr_valid_i  in  1  host row write request
- host_wr_addr_i  in  $clog2(SIZE)  host write row index
- host_wr_data_i  in  ROW_W  host write row data
- host_wr_ready_o  out  1  host write accepted this cycle when high with valid
- host_rd_valid_i  in  1  host row read request
- host_rd_addr_i  in  $clog2(SIZE)  host read row index
- host_rd_ready_o  out  1  host read accepted this cycle
- host_rd_data_o  out  ROW_W  read data
- host_rd_data_valid_o  out  1  read data valid, 1 cycle after accept
- eng_start_o  out  1  one-cycle start pulse to engine
- eng_flush_o  out  1  one-cycle flush pulse to engine
- eng_busy_i  in  1  engine busy indication
- eng_rd_valid_i  in  1  engine row read request
- eng_rd_addr_i  in  $clog2(SIZE)  engine read row index
- eng_row_o  out  ROW_W  engine read data
- eng_row_addr_o  out  $clog2(SIZE)  echoed read address
- eng_row_valid_o  out  1  engine read data valid
- eng_wr_valid_i  in  1  engine write-back request
- eng_wr_addr_i  in  $clog2(SIZE)  write-back row index
- eng_wr_data_i  in  ROW_W  write-back data
- eng_wr_ready_o  out  1  engine write accepted
- done_o  out  1  one-cycle run-complete pulse
- err_o  out  1  one-cycle pulse: start rejected
- state_o  out  2  IDLE=0, START=1, RUN=2, DONE=3
- run_cycles_o  out  16  cycles spent in RUN for the last or current run, saturating at 0xFFFF

## Operation
- Storage: SIZE × ROW_W register array, not reset. loaded mask (SIZE bits) is reset to 0. An accepted host write sets the mask bit for its row.
- IDLE:
  - host_wr_ready_o=1.
  - host_rd_ready_o=!host_wr_valid_i: a host write beats a host read in the same cycle.
  - Engine ports are ignored: eng_wr_ready_o=0, engine reads produce no valid.
- start_i in IDLE:
  - If the mask is all ones, go to START.
  - Otherwise pulse err_o and stay in IDLE.
  - start_i in other states is ignored.
- START: one cycle. eng_start_o=1 and run_cycles_o is cleared. Next state is RUN.
- RUN:
  - Host ready outputs are 0.
  - eng_wr_ready_o=1.
  - Engine reads are always accepted.
  - Completion: move to DONE on the first cycle with eng_busy_i=0 after at least one cycle in RUN with eng_busy_i=1. A seen_busy flag tracks this and is cleared in START.
  - run_cycles_o increments each RUN cycle.
- DONE: one cycle. done_o=1, then IDLE. The mask is kept, so a restart without reload is legal.
- flush_i (any state, priority over all transitions):
  - Next state is IDLE and the mask is cleared.
  - eng_flush_o pulses in the next cycle when the state was not IDLE.
  - An in-flight read-data valid is suppressed.
- Reset: every output is 0, state is IDLE, the mask and seen_busy are 0, and run_cycles_o is 0.

## Timing
- Read latency is 1 cycle on both sides. Data, echoed address and valid are registered. Valid is high exactly one cycle per accepted request.
- Reads are read-first: a read and a write to the same row in the same cycle return the old data. The new data is visible to reads accepted in the next cycle.
- Engine throughput is one read plus one write per cycle with no bubbles.
- host_wr_ready_o and host_rd_ready_o are combinational from state and host_wr_valid_i. They drop to 0 in the START cycle.
- Minimum start_i → done_o is 4 cycles (START, RUN with busy=1, RUN with busy=0, DONE).
- flush_i and start_i in the same IDLE cycle: flush wins, the mask clears, and err_o is not asserted.

## Test plan
- Load, run, unload:
  - Host writes rows 0..3 (row r all elements = r+1.0).
  - Pulse start_i, then engine reads row 2.
  - Expect eng_row_o = row 2 data and eng_row_addr_o=2 one cycle later.
  - Engine writes row 2 = 7.0, holds busy 10 cycles, then drops it.
  - Expect done_o one cycle later, run_cycles_o = 11, and a host read of row 2 returning 7.0.
- Start with rows 0..2 loaded only: expect err_o pulse, state_o stays 0, eng_start_o never asserts.
- Same-cycle engine read and write of row 1 (old 2.0, new 9.0): expect the read to return 2.0 and the next read to return 9.0.
- Host access during RUN:
  - Assert host_wr_valid_i and host_rd_valid_i.
  - Expect both ready outputs at 0 and storage unchanged.
  - In IDLE, simultaneous host write and read: the write is accepted and the read is stalled one cycle.
- flush_i mid-RUN:
  - Expect eng_flush_o pulse, state 0, no done_o, and a read accepted that cycle producing no valid.
  - A following start_i gives err_o, because the mask is cleared.
- Assert rst_i mid-RUN asynchronously: all outputs 0 immediately, and eng_busy_i=0 afterward never produces done_o.

Source files
------------

// File: rtl/lu_row_mem_ctrl.sv
// Row-buffer controller for the LU engine: SIZE-row complex matrix storage,
// host load/unload while idle, exclusive engine access while running, and
// start/done/flush sequencing with a saturating run-cycle counter.
module lu_row_mem_ctrl #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned AW    = $clog2(SIZE),
  localparam int unsigned ROW_W = SIZE * 2 * WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic             host_wr_valid_i,
  input  logic [AW-1:0]    host_wr_addr_i,
  input  logic [ROW_W-1:0] host_wr_data_i,
  output logic             host_wr_ready_o,
  input  logic             host_rd_valid_i,
  input  logic [AW-1:0]    host_rd_addr_i,
  output logic             host_rd_ready_o,
  output logic [ROW_W-1:0] host_rd_data_o,
  output logic             host_rd_data_valid_o,
  output logic             eng_start_o,
  output logic             eng_flush_o,
  input  logic             eng_busy_i,
  input  logic             eng_rd_valid_i,
  input  logic [AW-1:0]    eng_rd_addr_i,
  output logic [ROW_W-1:0] eng_row_o,
  output logic [AW-1:0]    eng_row_addr_o,
  output logic             eng_row_valid_o,
  input  logic             eng_wr_valid_i,
  input  logic [AW-1:0]    eng_wr_addr_i,
  input  logic [ROW_W-1:0] eng_wr_data_i,
  output logic             eng_wr_ready_o,
  output logic             done_o,
  output logic             err_o,
  output logic [1:0]       state_o,
  output logic [15:0]      run_cycles_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StRun   = 2'd2,
    StDone  = 2'd3
  } state_t;

  state_t             state_q;
  logic [SIZE-1:0]    mask_q;
  logic               seen_busy_q;
  logic [ROW_W-1:0]   mem_q [SIZE];

  logic host_wr_acc, host_rd_acc, eng_rd_acc, eng_wr_acc;

  // Host readies are held low while reset is asserted so every output reads 0.
  assign host_wr_ready_o = (state_q == StIdle) && !rst_i;
  assign host_rd_ready_o = (state_q == StIdle) && !host_wr_valid_i && !rst_i;
  assign eng_wr_ready_o  = (state_q == StRun);

  assign host_wr_acc = host_wr_valid_i && host_wr_ready_o;
  assign host_rd_acc = host_rd_valid_i && host_rd_ready_o;
  assign eng_rd_acc  = eng_rd_valid_i && (state_q == StRun);
  assign eng_wr_acc  = eng_wr_valid_i && eng_wr_ready_o;

  assign state_o = state_q;

  // Row storage, not reset; host and engine writes never coincide (state-exclusive).
  always_ff @(posedge clk_i) begin
    if (host_wr_acc) mem_q[host_wr_addr_i] <= host_wr_data_i;
    if (eng_wr_acc)  mem_q[eng_wr_addr_i]  <= eng_wr_data_i;
  end

  // Control FSM with registered pulses, read ports (read-first) and run counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q              <= StIdle;
      mask_q               <= '0;
      seen_busy_q          <= 1'b0;
      run_cycles_o         <= '0;
      eng_start_o          <= 1'b0;
      eng_flush_o          <= 1'b0;
      done_o               <= 1'b0;
      err_o                <= 1'b0;
      host_rd_data_o       <= '0;
      host_rd_data_valid_o <= 1'b0;
      eng_row_o            <= '0;
      eng_row_addr_o       <= '0;
      eng_row_valid_o      <= 1'b0;
    end else begin
      eng_start_o <= 1'b0;
      eng_flush_o <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;

      // A read accepted in a flush cycle returns no valid.
      host_rd_data_valid_o <= host_rd_acc && !flush_i;
      if (host_rd_acc) host_rd_data_o <= mem_q[host_rd_addr_i];
      eng_row_valid_o <= eng_rd_acc && !flush_i;
      if (eng_rd_acc) begin
        eng_row_o      <= mem_q[eng_rd_addr_i];
        eng_row_addr_o <= eng_rd_addr_i;
      end

      if (flush_i) begin
        state_q     <= StIdle;
        mask_q      <= '0;
        eng_flush_o <= (state_q != StIdle);
      end else begin
        if (host_wr_acc) mask_q[host_wr_addr_i] <= 1'b1;
        unique case (state_q)
          StIdle: begin
            if (start_i) begin
              if (&mask_q) begin
                state_q      <= StStart;
                eng_start_o  <= 1'b1;
                run_cycles_o <= '0;
                seen_busy_q  <= 1'b0;
              end else begin
                err_o <= 1'b1;
              end
            end
          end
          StStart: state_q <= StRun;
          StRun: begin
            if (run_cycles_o != 16'hFFFF) run_cycles_o <= run_cycles_o + 16'd1;
            if (eng_busy_i) seen_busy_q <= 1'b1;
            if (!eng_busy_i && seen_busy_q) begin
              state_q <= StDone;
              done_o  <= 1'b1;
            end
          end
          StDone: state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lu_row_mem_ctrl.sv
// Self-checking bench for lu_row_mem_ctrl: scoreboard queues for both read
// ports, directed control sequences for start/done/err/flush/reset.
module tb_lu_row_mem_ctrl;

  localparam int unsigned SIZE  = 4;
  localparam int unsigned WIDTH = 64;
  localparam int unsigned AW    = $clog2(SIZE);
  localparam int unsigned ROW_W = SIZE * 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0, flush = 1'b0;
  logic             host_wr_valid = 1'b0, host_rd_valid = 1'b0;
  logic [AW-1:0]    host_wr_addr = '0, host_rd_addr = '0;
  logic [ROW_W-1:0] host_wr_data = '0;
  logic             host_wr_ready, host_rd_ready, host_rd_data_valid;
  logic [ROW_W-1:0] host_rd_data;
  logic             eng_start, eng_flush, eng_busy = 1'b0;
  logic             eng_rd_valid = 1'b0, eng_wr_valid = 1'b0;
  logic [AW-1:0]    eng_rd_addr = '0, eng_wr_addr = '0, eng_row_addr;
  logic [ROW_W-1:0] eng_wr_data = '0, eng_row;
  logic             eng_row_valid, eng_wr_ready, done, err;
  logic [1:0]       state;
  logic [15:0]      run_cycles;

  lu_row_mem_ctrl #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
    .host_wr_valid_i(host_wr_valid), .host_wr_addr_i(host_wr_addr),
    .host_wr_data_i(host_wr_data), .host_wr_ready_o(host_wr_ready),
    .host_rd_valid_i(host_rd_valid), .host_rd_addr_i(host_rd_addr),
    .host_rd_ready_o(host_rd_ready), .host_rd_data_o(host_rd_data),
    .host_rd_data_valid_o(host_rd_data_valid),
    .eng_start_o(eng_start), .eng_flush_o(eng_flush), .eng_busy_i(eng_busy),
    .eng_rd_valid_i(eng_rd_valid), .eng_rd_addr_i(eng_rd_addr),
    .eng_row_o(eng_row), .eng_row_addr_o(eng_row_addr), .eng_row_valid_o(eng_row_valid),
    .eng_wr_valid_i(eng_wr_valid), .eng_wr_addr_i(eng_wr_addr),
    .eng_wr_data_i(eng_wr_data), .eng_wr_ready_o(eng_wr_ready),
    .done_o(done), .err_o(err), .state_o(state), .run_cycles_o(run_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int start_cnt = 0;

  logic [ROW_W-1:0] model [SIZE];
  logic [ROW_W-1:0] host_q [$];
  logic [ROW_W-1:0] eng_dq [$];
  logic [AW-1:0]    eng_aq [$];

  task automatic check(input string tag, input logic [ROW_W-1:0] got,
                       input logic [ROW_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] mk_row(input real v);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int j = 0; j < SIZE; j++) r[j*2*WIDTH +: 2*WIDTH] = {{WIDTH{1'b0}}, $realtobits(v)};
    return r;
  endfunction

  // Read-data monitors pop the scoreboard; pulse counters for control outputs.
  always @(negedge clk) begin
    if (host_rd_data_valid) begin
      check("host_rd_expected", (host_q.size() != 0), 1);
      if (host_q.size() != 0) check("host_rd_data", host_rd_data, host_q.pop_front());
    end
    if (eng_row_valid) begin
      check("eng_rd_expected", (eng_dq.size() != 0), 1);
      if (eng_dq.size() != 0) begin
        check("eng_row", eng_row, eng_dq.pop_front());
        check("eng_row_addr", eng_row_addr, eng_aq.pop_front());
      end
    end
    if (done) done_cnt++;
    if (eng_start) start_cnt++;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic host_write(input int r, input logic [ROW_W-1:0] d);
    host_wr_valid = 1'b1; host_wr_addr = AW'(r); host_wr_data = d;
    model[r] = d;
    step();
    host_wr_valid = 1'b0;
  endtask

  task automatic host_read(input int r);
    host_rd_valid = 1'b1; host_rd_addr = AW'(r);
    host_q.push_back(model[r]);
    step();
    host_rd_valid = 1'b0;
  endtask

  task automatic eng_rd(input int r);
    eng_rd_valid = 1'b1; eng_rd_addr = AW'(r);
    eng_dq.push_back(model[r]);
    eng_aq.push_back(AW'(r));
  endtask

  task automatic eng_wr(input int r, input logic [ROW_W-1:0] d);
    eng_wr_valid = 1'b1; eng_wr_addr = AW'(r); eng_wr_data = d;
    model[r] = d;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {host_wr_ready, host_rd_ready, host_rd_data_valid, eng_start, eng_flush,
                eng_row_valid, eng_wr_ready, done, err, state, run_cycles}, '0);
    check({tag, "_data"}, host_rd_data | eng_row, '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    step(); step();
    check_all_zero("reset_outs");
    rst = 1'b0;
    step();
    check("idle_wr_ready", host_wr_ready, 1);
    check("idle_state", state, 0);

    // Partial load then start: rejected.
    for (int r = 0; r < 3; r++) host_write(r, mk_row(real'(r + 1)));
    start = 1'b1;
    step();
    start = 1'b0;
    check("err_partial", err, 1);
    check("err_state", state, 0);
    step();
    check("err_pulse_end", err, 0);
    check("no_eng_start", start_cnt, 0);

    // Host write and read together in IDLE: write wins, read stalls one cycle.
    host_wr_valid = 1'b1; host_wr_addr = 2'd3; host_wr_data = mk_row(4.0); model[3] = mk_row(4.0);
    host_rd_valid = 1'b1; host_rd_addr = 2'd0;
    #1;
    check("coll_wr_ready", host_wr_ready, 1);
    check("coll_rd_ready", host_rd_ready, 0);
    step();
    host_wr_valid = 1'b0;
    #1;
    check("stall_rd_ready", host_rd_ready, 1);
    host_q.push_back(model[0]);
    step();
    host_rd_valid = 1'b0;

    // Full run.
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_state", state, 1);
    check("start_pulse", eng_start, 1);
    check("start_rc", run_cycles, 0);
    check("start_wr_ready", host_wr_ready, 0);
    eng_busy = 1'b1;
    step();
    check("run_state", state, 2);
    for (int i = 0; i < 10; i++) begin
      check("run_rc", run_cycles, 16'(i));
      eng_rd_valid = 1'b0; eng_wr_valid = 1'b0; host_wr_valid = 1'b0; host_rd_valid = 1'b0;
      case (i)
        0: eng_rd(2);
        1: eng_wr(2, mk_row(7.0));
        2: begin
          host_wr_valid = 1'b1; host_wr_addr = 2'd0; host_wr_data = mk_row(5.0);
          host_rd_valid = 1'b1; host_rd_addr = 2'd0;
          #1;
          check("run_host_rdy", {host_wr_ready, host_rd_ready}, 0);
          check("run_eng_wr_ready", eng_wr_ready, 1);
        end
        3: begin eng_rd(1); eng_wr(1, mk_row(9.0)); end
        4: eng_rd(1);
        5: eng_rd(0);
        default: ;
      endcase
      step();
    end
    eng_rd_valid = 1'b0; eng_wr_valid = 1'b0; host_wr_valid = 1'b0; host_rd_valid = 1'b0;
    check("run_no_done_yet", done_cnt, 0);
    eng_busy = 1'b0;
    step();
    check("done_state", state, 3);
    check("done_pulse", done, 1);
    check("done_rc", run_cycles, 11);
    step();
    check("post_done_state", state, 0);
    check("post_done_pulse", done, 0);
    check("post_done_rc", run_cycles, 11);
    host_read(2);
    host_read(1);

    // Restart without reload, then flush mid-run.
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_state", state, 1);
    eng_busy = 1'b1;
    step(); step();
    flush = 1'b1;
    eng_rd_valid = 1'b1; eng_rd_addr = 2'd0;
    step();
    flush = 1'b0; eng_rd_valid = 1'b0; eng_busy = 1'b0;
    check("flush_state", state, 0);
    check("flush_pulse", eng_flush, 1);
    check("flush_no_valid", eng_row_valid, 0);
    step();
    check("flush_pulse_end", eng_flush, 0);
    check("flush_no_done", done_cnt, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("flush_err", err, 1);
    start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    check("flush_start_err", err, 0);
    check("idle_flush_nopulse", eng_flush, 0);

    // Async reset mid-run.
    for (int r = 0; r < SIZE; r++) host_write(r, mk_row(real'(r + 1)));
    start = 1'b1;
    step();
    start = 1'b0;
    eng_busy = 1'b1;
    step(); step();
    eng_rd_valid = 1'b1; eng_rd_addr = 2'd3;
    @(posedge clk);
    #2;
    check("pre_rst_valid", eng_row_valid, 1);
    rst = 1'b1;
    #1;
    check_all_zero("async_rst_outs");
    step();
    rst = 1'b0; eng_rd_valid = 1'b0; eng_busy = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("post_rst_state", state, 0);
    check("post_rst_no_done", done_cnt, 1);
    check("start_pulses", start_cnt, 3);
    check("host_q_empty", host_q.size(), 0);
    check("eng_q_empty", eng_dq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
